fir_mac_sequencer: RTL

Issue-level scheduler for the shared pipelined FP ALU in the W4823 FIR datapath. For each accepted input sample it writes the circular sample memory, then issues TAPS multiplies (sample × coefficient) into the register file. It accumulates the products into ALU_LAT interleaved partial sums, reduces those partials, and pulses `dout_valid` when the normalized result appears at the ALU output. It drives only addresses, enables, mux selects and opcodes; all data paths stay in the datapath.

---
 rtl/fir_mac_sequencer_pkg.sv | 40 ++++
 rtl/fir_mac_sequencer_if.sv | 41 ++++
 rtl/fir_mac_sequencer_issue_delay.sv | 38 +++
 rtl/fir_mac_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// fir_seq_pkg: shared encodings for the FIR MAC sequencer.
// Contents:
// - FSM state codes.
// - ALU opcodes.
// - Operand-mux select codes for the shared FP ALU.
// - Width of the partial-sum capture strobe.
package fir_seq_pkg;

  localparam int HOLD_W = 5;
  localparam int ST_W   = 4;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_IDLE  = 4'd0;
  localparam state_t S_LOAD  = 4'd1;
  localparam state_t S_MUL   = 4'd2;
  localparam state_t S_MWAIT = 4'd3;
  localparam state_t S_ACC   = 4'd4;
  localparam state_t S_HCAP  = 4'd5;
  localparam state_t S_RED   = 4'd6;
  localparam state_t S_OWAIT = 4'd7;
  localparam state_t S_DONE  = 4'd8;

  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;
  localparam logic [1:0] OP_ADDN = 2'b00;

  localparam logic [1:0] ASEL_DMEM = 2'd0;
  localparam logic [1:0] ASEL_ZERO = 2'd1;
  localparam logic [1:0] ASEL_SELF = 2'd2;
  localparam logic [1:0] ASEL_H0   = 2'd3;

  localparam logic [2:0] BSEL_CMEM = 3'd0;
  localparam logic [2:0] BSEL_RF   = 3'd1;
  localparam logic [2:0] BSEL_H1   = 3'd2;
  localparam logic [2:0] BSEL_H2   = 3'd3;
  localparam logic [2:0] BSEL_H3   = 3'd4;
  localparam logic [2:0] BSEL_H4   = 3'd5;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: control bundle between the FIR MAC sequencer and the
// W4823 datapath.
// master = sequencer: receives din_valid and drives every address, enable,
//          select and opcode.
// slave  = datapath/sample source: the mirror image.
interface fir_mac_sequencer_if #(
  parameter int AW = 6
) ();
  import fir_seq_pkg::*;

  logic              din_valid;
  logic              busy;
  logic              overrun;
  logic              dmem_we;
  logic [AW-1:0]     dmem_waddr;
  logic [AW-1:0]     dmem_raddr;
  logic [AW-1:0]     cmem_raddr;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [AW-1:0]     rf_raddr;
  logic [HOLD_W-1:0] hold_we;
  logic              alu_issue;
  logic [1:0]        alu_op;
  logic [1:0]        alu_asel;
  logic [2:0]        alu_bsel;
  logic              dout_valid;

  modport master (
    input  din_valid,
    output busy, overrun, dmem_we, dmem_waddr, dmem_raddr, cmem_raddr,
           rf_we, rf_waddr, rf_raddr, hold_we, alu_issue, alu_op,
           alu_asel, alu_bsel, dout_valid
  );

  modport slave (
    output din_valid,
    input  busy, overrun, dmem_we, dmem_waddr, dmem_raddr, cmem_raddr,
           rf_we, rf_waddr, rf_raddr, hold_we, alu_issue, alu_op,
           alu_asel, alu_bsel, dout_valid
  );
endinterface

// File: rtl/fir_mac_sequencer_issue_delay.sv
// fir_issue_delay: DEPTH-stage shift register that carries a product
// write-back (valid + register-file address) from its MUL issue cycle to the
// cycle the ALU delivers the product.
// Ports:
// - clk_i, rst_i: clock and asynchronous active-high reset.
// - vld_i, addr_i: MUL issued this cycle, and its product slot.
// - vld_o, addr_o: register-file write enable and address, DEPTH cycles later.
module fir_issue_delay #(
  parameter int DEPTH = 5,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_o
);

  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    addr_q [DEPTH];

  // Addresses are cleared too, so rf_waddr reads 0 straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      vld_q     <= {vld_q[DEPTH-2:0], vld_i};
      addr_q[0] <= addr_i;
      for (int i = 1; i < DEPTH; i++) addr_q[i] <= addr_q[i-1];
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: issue-level scheduler for the shared pipelined FP ALU.
// Per accepted sample it does the following:
// - writes sample memory;
// - issues TAPS multiplies;
// - accumulates them into ALU_LAT interleaved partial sums;
// - captures the partials into H0-H4;
// - reduces them with a final normalizing add, and flags the result.
// Ports:
// - clk2: fast clock.
// - rst: asynchronous active-high reset.
// - bus: control bundle.
// All bus outputs are registered except the three read addresses, which are
// decoded from registered state/counters only.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS    = 64,
  parameter int ALU_LAT = 5,
  parameter int AW      = 6
) (
  input  logic               clk2,
  input  logic               rst,
  fir_mac_sequencer_if.master bus
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_TAPS_M1 = CW'(TAPS - 1);
  localparam logic [CW-1:0] C_L_M1    = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] C_L_M2    = CW'(ALU_LAT - 2);
  localparam logic [CW-1:0] C_L       = CW'(ALU_LAT);
  localparam logic [CW-1:0] C_2L      = CW'(2 * ALU_LAT);
  localparam logic [CW-1:0] C_3L      = CW'(3 * ALU_LAT);
  localparam logic [CW-1:0] C_HOLD    = CW'(HOLD_W);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wptr_q, wptr_d;

  logic              issue_d, issue_q;
  logic [1:0]        op_d, op_q;
  logic [1:0]        asel_d, asel_q;
  logic [2:0]        bsel_d, bsel_q;
  logic [HOLD_W-1:0] hold_d, hold_q;
  logic              dmem_we_q, busy_q, dout_q, overrun_q;
  logic [AW-1:0]     dmem_waddr_q;

  // Sequencing: counter restarts at 0 on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    wptr_d  = wptr_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.din_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_MUL;
        cnt_d   = '0;
      end
      S_MUL: if (cnt_q == C_TAPS_M1) begin
        state_d = S_MWAIT;
        cnt_d   = '0;
        wptr_d  = wptr_q + 1'b1;
      end
      S_MWAIT: if (cnt_q == C_L_M1) begin
        state_d = S_ACC;
        cnt_d   = '0;
      end
      S_ACC: if (cnt_q == C_TAPS_M1) begin
        state_d = S_HCAP;
        cnt_d   = '0;
      end
      S_HCAP: if (cnt_q == C_L_M1) begin
        state_d = S_RED;
        cnt_d   = '0;
      end
      S_RED: if (cnt_q == C_3L) begin
        state_d = S_OWAIT;
        cnt_d   = '0;
      end
      S_OWAIT: if (cnt_q == C_L_M2) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe. ALU selects hold when nothing issues.
  always_comb begin
    issue_d = 1'b0;
    op_d    = op_q;
    asel_d  = asel_q;
    bsel_d  = bsel_q;
    hold_d  = '0;
    unique case (state_d)
      S_MUL: begin
        issue_d = 1'b1;
        op_d    = OP_MUL;
        asel_d  = ASEL_DMEM;
        bsel_d  = BSEL_CMEM;
      end
      S_ACC: begin
        issue_d = 1'b1;
        op_d    = OP_ADD;
        // First ALU_LAT adds seed the interleaved partial sums from zero.
        asel_d  = (cnt_d < C_L) ? ASEL_ZERO : ASEL_SELF;
        bsel_d  = BSEL_RF;
      end
      S_HCAP: if (cnt_d < C_HOLD) hold_d = HOLD_W'(1) << cnt_d;
      S_RED: begin
        // Reduction chain: each add waits a full ALU latency for SELF.
        if (cnt_d == '0) begin
          issue_d = 1'b1; op_d = OP_ADD;  asel_d = ASEL_H0;   bsel_d = BSEL_H1;
        end else if (cnt_d == C_L) begin
          issue_d = 1'b1; op_d = OP_ADD;  asel_d = ASEL_SELF; bsel_d = BSEL_H2;
        end else if (cnt_d == C_2L) begin
          issue_d = 1'b1; op_d = OP_ADD;  asel_d = ASEL_SELF; bsel_d = BSEL_H3;
        end else if (cnt_d == C_3L) begin
          issue_d = 1'b1; op_d = OP_ADDN; asel_d = ASEL_SELF; bsel_d = BSEL_H4;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wptr_q       <= '0;
      issue_q      <= 1'b0;
      op_q         <= OP_ADD;
      asel_q       <= ASEL_DMEM;
      bsel_q       <= BSEL_CMEM;
      hold_q       <= '0;
      dmem_we_q    <= 1'b0;
      dmem_waddr_q <= '0;
      busy_q       <= 1'b0;
      dout_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      issue_q      <= issue_d;
      op_q         <= op_d;
      asel_q       <= asel_d;
      bsel_q       <= bsel_d;
      hold_q       <= hold_d;
      dmem_we_q    <= (state_d == S_LOAD);
      if (state_d == S_LOAD) dmem_waddr_q <= wptr_q;
      busy_q       <= (state_d != S_IDLE);
      dout_q       <= (state_d == S_DONE);
      // Samples arriving outside IDLE are dropped; only flag them.
      overrun_q    <= bus.din_valid && (state_q != S_IDLE);
    end
  end

  // MUL issue -> product write-back, ALU_LAT cycles later.
  fir_issue_delay #(
    .DEPTH (ALU_LAT),
    .AW    (AW)
  ) u_issue_delay (
    .clk_i  (clk2),
    .rst_i  (rst),
    .vld_i  (state_q == S_MUL),
    .addr_i (cnt_q[AW-1:0]),
    .vld_o  (bus.rf_we),
    .addr_o (bus.rf_waddr)
  );

  // Newest sample sits at wptr; tap k reads k samples back, modulo TAPS.
  assign bus.dmem_raddr = (state_q == S_MUL) ? (wptr_q - cnt_q[AW-1:0]) : '0;
  assign bus.cmem_raddr = (state_q == S_MUL) ? cnt_q[AW-1:0] : '0;
  assign bus.rf_raddr   = (state_q == S_ACC) ? cnt_q[AW-1:0] : '0;

  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_waddr = dmem_waddr_q;
  assign bus.hold_we    = hold_q;
  assign bus.alu_issue  = issue_q;
  assign bus.alu_op     = op_q;
  assign bus.alu_asel   = asel_q;
  assign bus.alu_bsel   = bsel_q;
  assign bus.dout_valid = dout_q;

endmodule
